// File: rtl/disaster_sensor_rx_if.sv
// Bundle of the serial line and the level/status outputs of disaster_sensor_rx.
// The master side is the sensor link plus the detector that reads the levels.
// The slave side is the receiver itself.
interface disaster_sensor_rx_if;
    logic rxd;
    logic r1, r0, s1, s0, w1, w0, l1, l0;
    logic frame_valid;
    logic parity_err;
    logic framing_err;
    logic stale;

    modport master (
        output rxd,
        input  r1, r0, s1, s0, w1, w0, l1, l0,
        input  frame_valid, parity_err, framing_err, stale
    );

    modport slave (
        input  rxd,
        output r1, r0, s1, s0, w1, w0, l1, l0,
        output frame_valid, parity_err, framing_err, stale
    );
endinterface

// File: rtl/disaster_sensor_rx.sv
// disaster_sensor_rx: UART-style sensor frame receiver.
// Frame: start(0), 8 data bits MSB first {r1 r0 s1 s0 w1 w0 l1 l0}, even parity, stop(1).
// Levels update only on a clean frame; stale flags data older than TIMEOUT_CYCLES.
// Optional feature macro SENSOR_PERSIST_EN: levels load only after two consecutive
// identical clean frames.
module disaster_sensor_rx #(
    parameter int CLKS_PER_BIT   = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                 clk,
    input  logic                 rst,
    disaster_sensor_rx_if.slave  bus
);
    localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
    localparam int STALE_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [BAUD_W-1:0]  HALF_BIT  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0]  LAST_TICK = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0]  BAUD_ONE  = BAUD_W'(1);
    localparam logic [STALE_W-1:0] STALE_MAX = STALE_W'(TIMEOUT_CYCLES);
    localparam logic [STALE_W-1:0] STALE_ONE = STALE_W'(1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // True when data plus parity bit hold an even number of ones.
    function automatic logic even_parity_ok(input logic [7:0] data, input logic par);
        return ~(^{data, par});
    endfunction

    logic               rxd_meta_r;
    logic               rxd_s;
    logic [2:0]         state_r;
    logic [BAUD_W-1:0]  baud_cnt_r;
    logic [2:0]         bit_cnt_r;
    logic [7:0]         shift_r;
    logic               par_bit_r;
    logic [7:0]         levels_r;
    logic               frame_valid_r;
    logic               parity_err_r;
    logic               framing_err_r;
    logic [STALE_W-1:0] stale_cnt_r;
    logic               stale_r;
    logic               stop_tick_s;
    logic               clean_s;
    logic               load_s;
`ifdef SENSOR_PERSIST_EN
    logic [7:0]         cand_r;
    logic               cand_valid_r;
`endif

    // Two-flop synchroniser for the asynchronous serial line, preset to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta_r <= 1'b1;
            rxd_s      <= 1'b1;
        end else begin
            rxd_meta_r <= bus.rxd;
            rxd_s      <= rxd_meta_r;
        end
    end

    // Decide whether the stop-bit sample completes a frame that loads the levels.
    always_comb begin
        stop_tick_s = 1'b0;
        clean_s     = 1'b0;
        load_s      = 1'b0;
        if ((state_r == ST_STOP) && (baud_cnt_r == LAST_TICK)) begin
            stop_tick_s = 1'b1;
        end else begin
            stop_tick_s = 1'b0;
        end
        if (stop_tick_s && rxd_s && even_parity_ok(shift_r, par_bit_r)) begin
            clean_s = 1'b1;
        end else begin
            clean_s = 1'b0;
        end
`ifdef SENSOR_PERSIST_EN
        if (clean_s && cand_valid_r && (cand_r == shift_r)) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end
`else
        load_s = clean_s;
`endif
    end

    // Frame FSM: bit timing, deserialisation, error pulses and level register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_IDLE;
            baud_cnt_r    <= '0;
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            par_bit_r     <= 1'b0;
            levels_r      <= 8'h00;
            frame_valid_r <= 1'b0;
            parity_err_r  <= 1'b0;
            framing_err_r <= 1'b0;
`ifdef SENSOR_PERSIST_EN
            cand_r        <= 8'h00;
            cand_valid_r  <= 1'b0;
`endif
        end else begin
            frame_valid_r <= load_s;
            parity_err_r  <= 1'b0;
            framing_err_r <= 1'b0;
            if (load_s) begin
                levels_r <= shift_r;
            end
            case (state_r)
                ST_IDLE: begin
                    baud_cnt_r <= '0;
                    if (!rxd_s) begin
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_cnt_r == HALF_BIT) begin
                        baud_cnt_r <= '0;
                        bit_cnt_r  <= 3'd0;
                        // A line that is high again at mid-start is only a glitch.
                        state_r    <= rxd_s ? ST_IDLE : ST_DATA;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    if (baud_cnt_r == LAST_TICK) begin
                        baud_cnt_r <= '0;
                        shift_r    <= {shift_r[6:0], rxd_s};
                        bit_cnt_r  <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            state_r <= ST_PARITY;
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_PARITY: begin
                    if (baud_cnt_r == LAST_TICK) begin
                        baud_cnt_r <= '0;
                        par_bit_r  <= rxd_s;
                        state_r    <= ST_STOP;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_STOP: begin
                    if (stop_tick_s) begin
                        baud_cnt_r <= '0;
                        if (!rxd_s) begin
                            // Bad stop bit wins over parity; wait out any break.
                            framing_err_r <= 1'b1;
                            state_r       <= ST_WAIT_HIGH;
`ifdef SENSOR_PERSIST_EN
                            cand_valid_r  <= 1'b0;
`endif
                        end else if (!clean_s) begin
                            parity_err_r  <= 1'b1;
                            state_r       <= ST_IDLE;
`ifdef SENSOR_PERSIST_EN
                            cand_valid_r  <= 1'b0;
`endif
                        end else begin
                            state_r       <= ST_IDLE;
`ifdef SENSOR_PERSIST_EN
                            cand_r        <= shift_r;
                            cand_valid_r  <= 1'b1;
`endif
                        end
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                ST_WAIT_HIGH: begin
                    baud_cnt_r <= '0;
                    if (rxd_s) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    baud_cnt_r <= '0;
                end
            endcase
        end
    end

    // Staleness timer: cleared with each level load, saturating at the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stale_cnt_r <= STALE_MAX;
            stale_r     <= 1'b1;
        end else begin
            if (load_s) begin
                stale_cnt_r <= '0;
            end else if (stale_cnt_r != STALE_MAX) begin
                stale_cnt_r <= stale_cnt_r + STALE_ONE;
            end
            stale_r <= (stale_cnt_r == STALE_MAX);
        end
    end

    assign bus.r1          = levels_r[7];
    assign bus.r0          = levels_r[6];
    assign bus.s1          = levels_r[5];
    assign bus.s0          = levels_r[4];
    assign bus.w1          = levels_r[3];
    assign bus.w0          = levels_r[2];
    assign bus.l1          = levels_r[1];
    assign bus.l0          = levels_r[0];
    assign bus.frame_valid = frame_valid_r;
    assign bus.parity_err  = parity_err_r;
    assign bus.framing_err = framing_err_r;
    assign bus.stale       = stale_r;
endmodule
